// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, data-memory wait freeze with timeout, and saturating debug counters.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_tar_reg,
  input  logic             i_mem_branch_taken,
  input  logic             i_mem_access,
  input  logic             i_dmem_ready,
  output logic             o_pc_write,
  output logic             o_pc_sel_branch,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_write,
  output logic             o_id_ex_bubble,
  output logic             o_ex_mem_write,
  output logic             o_ex_mem_flush,
  output logic             o_mem_wb_bubble,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // state    | meaning
  // RUN      | normal issue; load-use stall and branch flush handled here
  // MEM_WAIT | frozen while the data memory has not completed the access
  // ERR      | memory timeout; frozen until reset
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [15:0] WAIT_MAX_W = 16'(WAIT_MAX);

  state_t            state_q, state_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              lu, mw, eval_run;

  assign lu = i_ex_mem_read && (i_ex_tar_reg != 5'd0) &&
              ((i_ex_tar_reg == i_id_rs) || (i_id_uses_rt && (i_ex_tar_reg == i_id_rt)));
  assign mw = i_mem_access && !i_dmem_ready;

  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    err_d           = err_q;
    eval_run        = 1'b0;
    o_pc_write      = 1'b1;
    o_pc_sel_branch = 1'b0;
    o_if_id_write   = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_write   = 1'b1;
    o_id_ex_bubble  = 1'b0;
    o_ex_mem_write  = 1'b1;
    o_ex_mem_flush  = 1'b0;
    o_mem_wb_bubble = 1'b0;

    case (state_q)
      RUN: eval_run = 1'b1;
      MEM_WAIT: begin
        if (!mw) begin
          eval_run = 1'b1;
          state_d  = RUN;
          wcnt_d   = 16'd0;
        end else begin
          o_pc_write      = 1'b0;
          o_if_id_write   = 1'b0;
          o_id_ex_write   = 1'b0;
          o_ex_mem_write  = 1'b0;
          o_mem_wb_bubble = 1'b1;
          wcnt_d          = wcnt_q + 16'd1;
          if (wcnt_d >= WAIT_MAX_W) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      ERR: begin
        o_pc_write      = 1'b0;
        o_if_id_write   = 1'b0;
        o_id_ex_write   = 1'b0;
        o_ex_mem_write  = 1'b0;
        o_mem_wb_bubble = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (eval_run) begin
      if (mw) begin
        o_pc_write      = 1'b0;
        o_if_id_write   = 1'b0;
        o_id_ex_write   = 1'b0;
        o_ex_mem_write  = 1'b0;
        o_mem_wb_bubble = 1'b1;
        wcnt_d          = 16'd1;
        if (WAIT_MAX_W <= 16'd1) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          state_d = MEM_WAIT;
        end
      end else if (i_mem_branch_taken) begin
        // the ID instruction is discarded, so a load-use match is irrelevant
        o_pc_sel_branch = 1'b1;
        o_if_id_flush   = 1'b1;
        o_id_ex_bubble  = 1'b1;
        o_ex_mem_flush  = 1'b1;
      end else if (lu) begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b1;
      end
    end

    if (!i_rst_n) begin
      o_pc_write      = 1'b0;
      o_pc_sel_branch = 1'b0;
      o_if_id_write   = 1'b0;
      o_if_id_flush   = 1'b1;
      o_id_ex_write   = 1'b0;
      o_id_ex_bubble  = 1'b1;
      o_ex_mem_write  = 1'b0;
      o_ex_mem_flush  = 1'b1;
      o_mem_wb_bubble = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (!o_pc_write && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (o_pc_sel_branch && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      wcnt_q      <= 16'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_err       = i_rst_n && err_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (WAIT_MAX=5): reset, load-use, branch,
// memory wait with pending branch, timeout to ERR and counter saturation.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [4:0]  i_id_rs, i_id_rt, i_ex_tar_reg;
  logic        i_id_uses_rt, i_ex_mem_read, i_mem_branch_taken, i_mem_access, i_dmem_ready;
  logic        o_pc_write, o_pc_sel_branch, o_if_id_write, o_if_id_flush;
  logic        o_id_ex_write, o_id_ex_bubble, o_ex_mem_write, o_ex_mem_flush;
  logic        o_mem_wb_bubble, o_err;
  logic [15:0] o_stall_cnt, o_flush_cnt;
  logic [8:0]  ctl;

  int n_chk  = 0;
  int n_pass = 0;

  // {pc_w, pc_sel, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, exmem_flush, memwb_bub}
  localparam logic [8:0] C_RST  = 9'b000101011;
  localparam logic [8:0] C_NORM = 9'b101010100;
  localparam logic [8:0] C_LU   = 9'b000011100;
  localparam logic [8:0] C_BR   = 9'b111111110;
  localparam logic [8:0] C_FRZ  = 9'b000000001;

  pipe_hazard_ctrl #(.WAIT_MAX(5), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_uses_rt(i_id_uses_rt),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_tar_reg(i_ex_tar_reg),
    .i_mem_branch_taken(i_mem_branch_taken), .i_mem_access(i_mem_access),
    .i_dmem_ready(i_dmem_ready),
    .o_pc_write(o_pc_write), .o_pc_sel_branch(o_pc_sel_branch),
    .o_if_id_write(o_if_id_write), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_write(o_id_ex_write), .o_id_ex_bubble(o_id_ex_bubble),
    .o_ex_mem_write(o_ex_mem_write), .o_ex_mem_flush(o_ex_mem_flush),
    .o_mem_wb_bubble(o_mem_wb_bubble), .o_err(o_err),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  assign ctl = {o_pc_write, o_pc_sel_branch, o_if_id_write, o_if_id_flush, o_id_ex_write,
                o_id_ex_bubble, o_ex_mem_write, o_ex_mem_flush, o_mem_wb_bubble};

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // advance n rising edges, then settle just after the edge
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_id_rs = 5'd0; i_id_rt = 5'd0; i_id_uses_rt = 1'b0;
    i_ex_mem_read = 1'b0; i_ex_tar_reg = 5'd0;
    i_mem_branch_taken = 1'b0; i_mem_access = 1'b0; i_dmem_ready = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle_inputs();

    // 1: reset held three cycles, then release
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_ctl", 32'(ctl), 32'(C_RST));
      chk("rst_err", 32'(o_err), 32'd0);
    end
    chk("rst_stall", 32'(o_stall_cnt), 32'd0);
    i_rst_n = 1'b1; #1;
    chk("rel_ctl", 32'(ctl), 32'(C_NORM));
    step(1);
    chk("rel_stall", 32'(o_stall_cnt), 32'd0);
    chk("rel_flush", 32'(o_flush_cnt), 32'd0);

    // 2: load-use on rs, then on rt, and the non-hazard variants
    i_ex_mem_read = 1'b1; i_ex_tar_reg = 5'd8; i_id_rs = 5'd8; #1;
    chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    step(1);
    i_ex_mem_read = 1'b0; #1;
    chk("lu_after_ctl", 32'(ctl), 32'(C_NORM));
    chk("lu_stall1", 32'(o_stall_cnt), 32'd1);
    i_ex_mem_read = 1'b1; i_ex_tar_reg = 5'd0; i_id_rs = 5'd0; #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(C_NORM));
    i_ex_tar_reg = 5'd9; i_id_rs = 5'd3; i_id_rt = 5'd9; i_id_uses_rt = 1'b0; #1;
    chk("lu_rt_unused", 32'(ctl), 32'(C_NORM));
    i_id_uses_rt = 1'b1; #1;
    chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    step(1);
    idle_inputs(); #1;
    chk("lu_stall2", 32'(o_stall_cnt), 32'd2);

    // 3: taken branch overrides a simultaneous load-use
    i_mem_branch_taken = 1'b1; i_ex_mem_read = 1'b1; i_ex_tar_reg = 5'd8; i_id_rs = 5'd8; #1;
    chk("br_ctl", 32'(ctl), 32'(C_BR));
    step(1);
    idle_inputs(); #1;
    chk("br_flush", 32'(o_flush_cnt), 32'd1);
    chk("br_stall", 32'(o_stall_cnt), 32'd2);

    // 4: four frozen cycles with a pending branch, applied on the ready cycle
    i_mem_access = 1'b1; i_dmem_ready = 1'b0; i_mem_branch_taken = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("mw_frz_ctl", 32'(ctl), 32'(C_FRZ));
      step(1);
    end
    i_dmem_ready = 1'b1; #1;
    chk("mw_ready_ctl", 32'(ctl), 32'(C_BR));
    step(1);
    idle_inputs(); #1;
    chk("mw_stall", 32'(o_stall_cnt), 32'd6);
    chk("mw_flush", 32'(o_flush_cnt), 32'd2);
    chk("mw_err", 32'(o_err), 32'd0);
    chk("mw_run_ctl", 32'(ctl), 32'(C_NORM));

    // 5: timeout after WAIT_MAX=5 wait cycles
    i_rst_n = 1'b0; step(1);
    i_rst_n = 1'b1; #1;
    chk("t5_stall_clr", 32'(o_stall_cnt), 32'd0);
    chk("t5_flush_clr", 32'(o_flush_cnt), 32'd0);
    i_mem_access = 1'b1; i_dmem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("to_err_early", 32'(o_err), 32'd0);
    end
    step(1);
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_stall", 32'(o_stall_cnt), 32'd5);
    i_mem_access = 1'b0; i_dmem_ready = 1'b1; #1;
    chk("err_frz_ctl", 32'(ctl), 32'(C_FRZ));

    // 6: stay in ERR until the stall counter saturates
    step(65534 - 5);
    chk("sat_fffe", 32'(o_stall_cnt), 32'h0000_fffe);
    chk("sat_err_hold", 32'(o_err), 32'd1);
    step(1);
    chk("sat_ffff", 32'(o_stall_cnt), 32'h0000_ffff);
    step(3);
    chk("sat_hold", 32'(o_stall_cnt), 32'h0000_ffff);
    chk("sat_frz_ctl", 32'(ctl), 32'(C_FRZ));

    // reset leaves ERR
    i_rst_n = 1'b0; #1;
    chk("err_rst_ctl", 32'(ctl), 32'(C_RST));
    chk("err_rst_err", 32'(o_err), 32'd0);
    step(1);
    i_rst_n = 1'b1; #1;
    chk("post_rst_ctl", 32'(ctl), 32'(C_NORM));
    chk("post_rst_stall", 32'(o_stall_cnt), 32'd0);
    step(1);
    chk("post_rst_err", 32'(o_err), 32'd0);
    chk("post_rst_run", 32'(ctl), 32'(C_NORM));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
